// File: rtl/cordic_vector_gen_if.sv
// cordic_vector_gen_if
//   Handshake bundle for cordic_vector_gen.
//   Input side:  in_valid/in_ready with theta_in (signed rad*32768, 0..pi/2) and quad_in (0..3).
//   Output side: out_valid/out_ready with cx_out/cy_out (signed AMP*cos/sin of the angle).
//   master: the angle source / result sink. slave: the generator.
interface cordic_vector_gen_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] theta_in;
  logic [1:0]         quad_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] cx_out;
  logic signed [15:0] cy_out;

  modport master (
    output in_valid, theta_in, quad_in, out_ready,
    input  in_ready, out_valid, cx_out, cy_out
  );

  modport slave (
    input  in_valid, theta_in, quad_in, out_ready,
    output in_ready, out_valid, cx_out, cy_out
  );
endinterface

// File: rtl/cordic_vector_gen.sv
// cordic_vector_gen
//   Rotation-mode iterative CORDIC: turns (theta, quadrant) into the vector
//   AMP*(cos, sin) of quad*pi/2 + theta, one micro-rotation per clock.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cordic_vector_gen_if.slave (angle in, vector out, valid/ready both sides)
// Parameters
//   ITERS  : micro-rotations (8..16)
//   X_INIT : starting x in output LSBs, AMP*K with gain compensation
//   IW     : internal x/y width; the bits beyond the 16-bit output are
//            fractional guard bits (IW must be at least 17)
module cordic_vector_gen #(
  parameter int ITERS  = 16,
  parameter int X_INIT = 18218,
  parameter int IW     = 20
) (
  input logic              clk,
  input logic              rst,
  cordic_vector_gen_if.slave bus
);

  // x/y run with GUARD fractional bits below the output LSB so that the
  // truncation of each arithmetic shift stays well under one output LSB.
  localparam int                    GUARD     = IW - 16;
  localparam int                    QW        = IW - GUARD + 1;
  localparam logic [4:0]            LAST_ITER = 5'(ITERS - 1);
  localparam logic signed [IW-1:0]  X_START   = IW'(X_INIT) <<< GUARD;
  localparam logic signed [IW:0]    HALF_LSB  = (IW+1)'(2 ** (GUARD - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_POST = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t               state_r;
  logic signed [IW-1:0] x_r;
  logic signed [IW-1:0] y_r;
  logic signed [17:0]   z_r;
  logic [1:0]           quad_r;
  logic [4:0]           iter_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic signed [15:0]   cx_r;
  logic signed [15:0]   cy_r;

  logic signed [16:0]   theta_clamp_s;
  logic signed [IW-1:0] x_sh_s;
  logic signed [IW-1:0] y_sh_s;
  logic signed [IW-1:0] x_nx_s;
  logic signed [IW-1:0] y_nx_s;
  logic signed [17:0]   z_nx_s;
  logic signed [17:0]   atan_s;
  logic signed [IW-1:0] fold_x_s;
  logic signed [IW-1:0] fold_y_s;

  // round(atan(2^-i) * 32768)
  function automatic logic signed [17:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 18'sd25736;
      5'd1:    atan_lut = 18'sd15193;
      5'd2:    atan_lut = 18'sd8027;
      5'd3:    atan_lut = 18'sd4075;
      5'd4:    atan_lut = 18'sd2045;
      5'd5:    atan_lut = 18'sd1024;
      5'd6:    atan_lut = 18'sd512;
      5'd7:    atan_lut = 18'sd256;
      5'd8:    atan_lut = 18'sd128;
      5'd9:    atan_lut = 18'sd64;
      5'd10:   atan_lut = 18'sd32;
      5'd11:   atan_lut = 18'sd16;
      5'd12:   atan_lut = 18'sd8;
      5'd13:   atan_lut = 18'sd4;
      5'd14:   atan_lut = 18'sd2;
      5'd15:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  // Drop the guard bits (round half up) and saturate to 16 bits.
  function automatic logic signed [15:0] to_out(input logic signed [IW-1:0] v);
    logic signed [QW-1:0] q;
    q = QW'(($signed({v[IW-1], v}) + HALF_LSB) >>> GUARD);
    if (q[QW-1:15] == {(QW-15){q[QW-1]}}) begin
      to_out = q[15:0];
    end else if (q[QW-1]) begin
      to_out = 16'sh8000;
    end else begin
      to_out = 16'sh7FFF;
    end
  endfunction

  // Clamp the requested angle into the legal 0..pi/2 range
  always_comb begin
    theta_clamp_s = bus.theta_in;
    if (bus.theta_in < 17'sd0) begin
      theta_clamp_s = 17'sd0;
    end else if (bus.theta_in > 17'sd51472) begin
      theta_clamp_s = 17'sd51472;
    end else begin
      theta_clamp_s = bus.theta_in;
    end
  end

  // One micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    x_sh_s = x_r >>> iter_r;
    y_sh_s = y_r >>> iter_r;
    atan_s = atan_lut(iter_r);
    if (!z_r[17]) begin
      x_nx_s = x_r - y_sh_s;
      y_nx_s = y_r + x_sh_s;
      z_nx_s = z_r - atan_s;
    end else begin
      x_nx_s = x_r + y_sh_s;
      y_nx_s = y_r - x_sh_s;
      z_nx_s = z_r + atan_s;
    end
  end

  // Quadrant fold: rotate the first-quadrant vector by quad*pi/2
  always_comb begin
    fold_x_s = x_r;
    fold_y_s = y_r;
    case (quad_r)
      2'd0: begin fold_x_s = x_r;  fold_y_s = y_r;  end
      2'd1: begin fold_x_s = -y_r; fold_y_s = x_r;  end
      2'd2: begin fold_x_s = -x_r; fold_y_s = -y_r; end
      2'd3: begin fold_x_s = y_r;  fold_y_s = -x_r; end
      default: begin fold_x_s = x_r; fold_y_s = y_r; end
    endcase
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cx_r        <= 16'sd0;
      cy_r        <= 16'sd0;
      iter_r      <= 5'd0;
      x_r         <= {IW{1'b0}};
      y_r         <= {IW{1'b0}};
      z_r         <= 18'sd0;
      quad_r      <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            x_r        <= X_START;
            y_r        <= {IW{1'b0}};
            z_r        <= {theta_clamp_s[16], theta_clamp_s};
            quad_r     <= bus.quad_in;
            iter_r     <= 5'd0;
            in_ready_r <= 1'b0;
            state_r    <= ST_ITER;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_ITER: begin
          x_r <= x_nx_s;
          y_r <= y_nx_s;
          z_r <= z_nx_s;
          if (iter_r == LAST_ITER) begin
            iter_r  <= 5'd0;
            state_r <= ST_POST;
          end else begin
            iter_r <= iter_r + 5'd1;
          end
        end
        ST_POST: begin
          cx_r        <= to_out(fold_x_s);
          cy_r        <= to_out(fold_y_s);
          out_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready_ok()) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic out_ready_ok();
    out_ready_ok = out_valid_r & bus.out_ready;
  endfunction

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.cx_out    = cx_r;
  assign bus.cy_out    = cy_r;

endmodule

// File: tb/tb_cordic_vector_gen.sv
// Self-checking bench for cordic_vector_gen: directed corner angles plus
// random angles, compared against real-valued AMP*(cos, sin).
module tb_cordic_vector_gen;

  localparam real PI  = 3.14159265358979;
  localparam real AMP = 30000.0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cordic_vector_gen_if bus ();

  cordic_vector_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Reference: clamp theta, form the full angle, evaluate AMP*(cos, sin).
  task automatic ref_vec(input int theta, input int quad, output int ex, output int ey);
    int  t;
    real a;
    t = theta;
    if (t < 0) t = 0;
    if (t > 51472) t = 51472;
    a = quad * (PI / 2.0) + t / 32768.0;
    ex = int'(AMP * $cos(a));
    ey = int'(AMP * $sin(a));
  endtask

  // Full transaction: offer angle, measure latency, stall for 'hold' cycles, release.
  task automatic xfer(input int theta, input int quad, input int hold,
                      output int rx, output int ry);
    int n;
    @(negedge clk);
    bus.theta_in = 17'(theta);
    bus.quad_in  = 2'(quad);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", int'(bus.in_ready), 1, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_busy", int'(bus.in_ready), 0, 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 17, 0);
    rx = int'(bus.cx_out);
    ry = int'(bus.cy_out);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_cx", int'(bus.cx_out), rx, 0);
      chk("hold_cy", int'(bus.cy_out), ry, 0);
      chk("hold_valid", int'(bus.out_valid), 1, 0);
      chk("hold_in_ready", int'(bus.in_ready), 0, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_valid", int'(bus.out_valid), 0, 0);
    chk("release_in_ready", int'(bus.in_ready), 1, 0);
    chk("keep_cx", int'(bus.cx_out), rx, 0);
    @(negedge clk);
    chk("single_result", int'(bus.out_valid), 0, 0);
  endtask

  task automatic run_case(input string tag, input int theta, input int quad, input int hold);
    int rx, ry, ex, ey;
    xfer(theta, quad, hold, rx, ry);
    ref_vec(theta, quad, ex, ey);
    chk({tag, "_cx"}, rx, ex, 3);
    chk({tag, "_cy"}, ry, ey, 3);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_errors      = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.theta_in  = 17'sd0;
    bus.quad_in   = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_cx", int'(bus.cx_out), 0, 0);
    chk("rst_cy", int'(bus.cy_out), 0, 0);
    rst = 1'b0;

    run_case("t1_zero", 0, 0, 0);
    run_case("t2_45_q0", 25736, 0, 1);
    run_case("t2_45_q2", 25736, 2, 0);
    run_case("t3_q1", 0, 1, 0);
    run_case("t3_q3", 0, 3, 2);
    run_case("t3_neg", -100, 0, 0);
    run_case("t3_big", 60000, 0, 0);
    run_case("wrap_q0", 51472, 0, 0);
    run_case("wrap_q3", 51472, 3, 0);
    run_case("t4_stall", 12000, 1, 10);

    for (int i = 0; i < 40; i++) begin
      run_case("rand", int'($urandom_range(54000, 0)) - 1000,
               int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end

    // Leave a nonzero result on the outputs, then abort a computation midway.
    run_case("pre_abort", 20000, 2, 0);
    @(negedge clk);
    bus.theta_in = 17'sd10000;
    bus.quad_in  = 2'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(bus.out_valid), 0, 0);
    chk("abort_cx", int'(bus.cx_out), 0, 0);
    chk("abort_cy", int'(bus.cy_out), 0, 0);
    @(negedge clk);
    chk("abort_in_ready", int'(bus.in_ready), 1, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_partial", seen, 0, 0);
    run_case("post_abort", 30000, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
